// File: rtl/audio_i2s_tx.sv
// rtl/audio_i2s_tx.sv - stereo I2S / left-justified serial transmitter with sample-pair FIFO
// BCK/LRCK/DATA are plain registers in the iCLK_18_4 domain; the last frame repeats on underrun.
module audio_i2s_tx #(
   parameter int REF_CLK     = 18432000,
   parameter int SAMPLE_RATE = 48000,
   parameter int DATA_WIDTH  = 16,
   parameter int I2S_MODE    = 1,
   parameter int FIFO_DEPTH  = 4
) (
   input  logic                             iCLK_18_4,
   input  logic                             iRST_N,
   input  logic [DATA_WIDTH-1:0]            iSAMPLE_L,
   input  logic [DATA_WIDTH-1:0]            iSAMPLE_R,
   input  logic                             iVALID,
   output logic                             oREADY,
   output logic [$clog2(FIFO_DEPTH+1)-1:0]  oFIFO_LEVEL,
   output logic                             oUNDERRUN,
   output logic                             oAUD_BCK,
   output logic                             oAUD_LRCK,
   output logic                             oAUD_DATA
);

   localparam int BCK_HALF = REF_CLK / (SAMPLE_RATE * DATA_WIDTH * 4);
   localparam int FW       = 2 * DATA_WIDTH;
   localparam int DCW      = (BCK_HALF > 1) ? $clog2(BCK_HALF) : 1;
   localparam int BCW      = $clog2(FW);
   localparam int PW       = $clog2(FIFO_DEPTH);
   localparam int LW       = $clog2(FIFO_DEPTH + 1);

   localparam logic [DCW-1:0] DIV_LAST = DCW'(BCK_HALF - 1);
   localparam logic [BCW-1:0] BIT_LAST = BCW'(FW - 1);
   localparam logic [BCW-1:0] SLOT_R   = BCW'(DATA_WIDTH);
   localparam logic [LW-1:0]  LVL_FULL = LW'(FIFO_DEPTH);

   if (BCK_HALF < 1 || BCK_HALF * SAMPLE_RATE * DATA_WIDTH * 4 != REF_CLK) begin : g_bad_clk
      $error("audio_i2s_tx: REF_CLK is not an exact multiple of 4*SAMPLE_RATE*DATA_WIDTH");
   end
   if (DATA_WIDTH < 8 || DATA_WIDTH > 32) begin : g_bad_width
      $error("audio_i2s_tx: DATA_WIDTH must lie in 8..32");
   end
   if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
      $error("audio_i2s_tx: FIFO_DEPTH must be a power of 2, at least 2");
   end

   logic [DCW-1:0] div_cnt;
   logic           bck;
   logic           lrck;
   logic           underrun;
   logic [BCW-1:0] bit_cnt;
   logic [BCW-1:0] next_bit;
   logic [BCW-1:0] ahead_bit;
   logic           next_lrck;
   logic [FW-1:0]  shift;
   logic [FW-1:0]  last_pair;
   logic [FW-1:0]  mem [FIFO_DEPTH];
   logic [PW-1:0]  wr_ptr;
   logic [PW-1:0]  rd_ptr;
   logic [LW-1:0]  level;
   logic           div_tc;
   logic           fall;
   logic           frame_start;
   logic           push;
   logic           pop;

   assign div_tc      = (div_cnt == DIV_LAST);
   assign fall        = div_tc && bck;
   assign frame_start = fall && (bit_cnt == BIT_LAST);
   assign push        = iVALID && (level != LVL_FULL);
   assign pop         = frame_start && (level != '0);

   // In I2S mode LRCK looks one bit ahead so it switches on the previous slot's LSB.
   always_comb begin
      next_bit  = (bit_cnt == BIT_LAST) ? '0 : bit_cnt + 1'b1;
      ahead_bit = (next_bit == BIT_LAST) ? '0 : next_bit + 1'b1;
      next_lrck = (I2S_MODE != 0) ? (ahead_bit >= SLOT_R) : (next_bit >= SLOT_R);
   end

   always_ff @(posedge iCLK_18_4 or negedge iRST_N) begin
      if (!iRST_N) begin
         div_cnt   <= '0;
         bck       <= 1'b0;
         lrck      <= 1'b0;
         underrun  <= 1'b0;
         bit_cnt   <= '0;
         shift     <= '0;
         last_pair <= '0;
         wr_ptr    <= '0;
         rd_ptr    <= '0;
         level     <= '0;
      end else begin
         div_cnt  <= div_tc ? '0 : div_cnt + 1'b1;
         underrun <= frame_start && (level == '0);
         if (div_tc) begin
            bck <= ~bck;
         end
         if (fall) begin
            bit_cnt <= next_bit;
            lrck    <= next_lrck;
            if (frame_start) begin
               if (pop) begin
                  shift     <= mem[rd_ptr];
                  last_pair <= mem[rd_ptr];
               end else begin
                  shift <= last_pair;
               end
            end else begin
               shift <= {shift[FW-2:0], 1'b0};
            end
         end
         if (push) begin
            wr_ptr <= wr_ptr + 1'b1;
         end
         if (pop) begin
            rd_ptr <= rd_ptr + 1'b1;
         end
         case ({push, pop})
            2'b10:   level <= level + 1'b1;
            2'b01:   level <= level - 1'b1;
            default: level <= level;
         endcase
      end
   end

   // Storage needs no reset: pointers and level define which entries are live.
   always_ff @(posedge iCLK_18_4) begin
      if (push) begin
         mem[wr_ptr] <= {iSAMPLE_L, iSAMPLE_R};
      end
   end

   assign oREADY      = (level != LVL_FULL);
   assign oFIFO_LEVEL = level;
   assign oUNDERRUN   = underrun;
   assign oAUD_BCK    = bck;
   assign oAUD_LRCK   = lrck;
   assign oAUD_DATA   = shift[FW-1];

endmodule
